// File: rtl/rc4_engine.sv
// rc4_engine: RC4 decryption engine behind the MCU RC4_start/RC4_done handshake.
// A start latches the key and byte count. The engine then runs the key schedule
// on an internal 256-byte S-box and XORs the keystream with the ciphertext
// stream.
// Optional build macro: RC4_DROP256_EN. When it is defined, the engine discards
// the first 256 keystream bytes (RC4-drop[256]) before it accepts ciphertext.
//
// Handshake semantics for cipher_in:
//   A byte is transferred on a rising edge where cipher_valid && cipher_ready.
//   cipher_ready is a pure function of state and does not depend on
//   cipher_valid. plain_out has no backpressure. plain_valid is a one-cycle
//   strobe and the consumer must take the byte in that cycle.
module rc4_engine #(
    parameter int KEY_BYTES = 16,
    parameter int NUM_W     = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   RC4_start,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [NUM_W-1:0]       num_bytes,
    input  logic [7:0]             cipher_in,
    input  logic                   cipher_valid,
    output logic                   cipher_ready,
    output logic [7:0]             plain_out,
    output logic                   plain_valid,
    output logic                   RC4_done,
    output logic                   busy,
    output logic [2:0]             state_dbg_o
);

    localparam int KI_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_INIT = 3'd1,
        ST_KSA  = 3'd2,
        ST_STEP = 3'd4,
        ST_OUT  = 3'd5,
        ST_DONE = 3'd6
`ifdef RC4_DROP256_EN
        , ST_DROP = 3'd3
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [KI_W-1:0]   ki_q, ki_d;
    logic [NUM_W-1:0]  cnt_q, cnt_d;
    logic [NUM_W-1:0]  num_q, num_d;
    logic [7:0]        key_q [KEY_BYTES];
    logic [7:0]        key_d [KEY_BYTES];
    logic [7:0]        byte_q, byte_d;
    logic [7:0]        ks_q, ks_d;        // decrypted byte waiting to be presented
    logic              pend_q, pend_d;    // ks_q holds a byte for plain_out
    logic [7:0]        plain_out_q, plain_out_d;
    logic              plain_valid_q, plain_valid_d;

    // S-box and its write controls
    logic [7:0]        s_q [256];
    logic              s_init;
    logic              s_swap;
    logic [7:0]        swap_a, swap_b;
    logic [7:0]        val_a, val_b;

    // Index arithmetic, all mod 256
    logic [7:0]        ksa_j;
    logic [7:0]        prga_i, prga_j;
    logic [7:0]        out_t;

    assign ksa_j  = j_q + s_q[i_q] + key_q[ki_q];
    assign prga_i = i_q + 8'd1;
    assign prga_j = j_q + s_q[prga_i];
    assign out_t  = s_q[i_q] + s_q[j_q];
    assign val_a  = s_q[swap_a];
    assign val_b  = s_q[swap_b];

    // Next-state, datapath control and output pipeline
    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        ki_d          = ki_q;
        cnt_d         = cnt_q;
        num_d         = num_q;
        key_d         = key_q;
        byte_d        = byte_q;
        ks_d          = ks_q;
        pend_d        = 1'b0;
        s_init        = 1'b0;
        s_swap        = 1'b0;
        swap_a        = 8'd0;
        swap_b        = 8'd0;
        plain_out_d   = pend_q ? ks_q : plain_out_q;
        plain_valid_d = pend_q;

        case (state_q)
            ST_IDLE: begin
                if (RC4_start) begin
                    for (int k = 0; k < KEY_BYTES; k++) begin
                        key_d[k] = key[8*k +: 8];
                    end
                    num_d   = num_bytes;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                s_init  = 1'b1;
                i_d     = 8'd0;
                j_d     = 8'd0;
                ki_d    = '0;
                cnt_d   = '0;
                state_d = ST_KSA;
            end
            ST_KSA: begin
                s_swap = 1'b1;
                swap_a = i_q;
                swap_b = ksa_j;
                j_d    = ksa_j;
                i_d    = i_q + 8'd1;
                ki_d   = (ki_q == KI_W'(KEY_BYTES - 1)) ? '0 : ki_q + KI_W'(1);
                if (i_q == 8'hFF) begin
                    i_d = 8'd0;
                    j_d = 8'd0;
`ifdef RC4_DROP256_EN
                    state_d = ST_DROP;
`else
                    state_d = ST_STEP;
`endif
                end
            end
`ifdef RC4_DROP256_EN
            ST_DROP: begin
                // Discarded PRGA rounds; i returning to 0 marks the 256th
                s_swap = 1'b1;
                swap_a = prga_i;
                swap_b = prga_j;
                i_d    = prga_i;
                j_d    = prga_j;
                if (prga_i == 8'd0) begin
                    state_d = ST_STEP;
                end
            end
`endif
            ST_STEP: begin
                if (num_q == '0) begin
                    state_d = ST_DONE;
                end else if (cipher_valid) begin
                    byte_d  = cipher_in;
                    s_swap  = 1'b1;
                    swap_a  = prga_i;
                    swap_b  = prga_j;
                    i_d     = prga_i;
                    j_d     = prga_j;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                ks_d   = byte_q ^ s_q[out_t];
                pend_d = 1'b1;
                cnt_d  = cnt_q + NUM_W'(1);
                state_d = (cnt_d == num_q) ? ST_DONE : ST_STEP;
            end
            ST_DONE: begin
                if (!RC4_start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and pipeline registers with asynchronous reset
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            i_q           <= 8'd0;
            j_q           <= 8'd0;
            ki_q          <= '0;
            cnt_q         <= '0;
            num_q         <= '0;
            for (int k = 0; k < KEY_BYTES; k++) begin
                key_q[k] <= 8'd0;
            end
            byte_q        <= 8'd0;
            ks_q          <= 8'd0;
            pend_q        <= 1'b0;
            plain_out_q   <= 8'd0;
            plain_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            ki_q          <= ki_d;
            cnt_q         <= cnt_d;
            num_q         <= num_d;
            key_q         <= key_d;
            byte_q        <= byte_d;
            ks_q          <= ks_d;
            pend_q        <= pend_d;
            plain_out_q   <= plain_out_d;
            plain_valid_q <= plain_valid_d;
        end
    end

    // S-box storage: identity fill or a single swap per cycle. INIT always
    // rewrites it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (s_init) begin
            for (int k = 0; k < 256; k++) begin
                s_q[k] <= 8'(k);
            end
        end else if (s_swap) begin
            s_q[swap_a] <= val_b;
            s_q[swap_b] <= val_a;
        end
    end

    assign cipher_ready = (state_q == ST_STEP) && (num_q != '0);
    assign plain_out    = plain_out_q;
    assign plain_valid  = plain_valid_q;
    assign RC4_done     = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_rc4_engine.sv
// tb_rc4_engine: directed bench for rc4_engine using the "Key"/"Plaintext" vector.
// Build with RC4_DROP256_EN defined to check the drop[256] variant against a
// small reference model.
module tb_rc4_engine;

    localparam int KEY_BYTES = 3;
    localparam int NUM_W     = 16;
`ifdef RC4_DROP256_EN
    localparam int READY_LAT = 513;
`else
    localparam int READY_LAT = 257;
`endif

    logic                   clk;
    logic                   n_rst;
    logic                   RC4_start;
    logic [8*KEY_BYTES-1:0] key;
    logic [NUM_W-1:0]       num_bytes;
    logic [7:0]             cipher_in;
    logic                   cipher_valid;
    logic                   cipher_ready;
    logic [7:0]             plain_out;
    logic                   plain_valid;
    logic                   RC4_done;
    logic                   busy;
    logic [2:0]             state_dbg;

    rc4_engine #(.KEY_BYTES(KEY_BYTES), .NUM_W(NUM_W)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .RC4_start    (RC4_start),
        .key          (key),
        .num_bytes    (num_bytes),
        .cipher_in    (cipher_in),
        .cipher_valid (cipher_valid),
        .cipher_ready (cipher_ready),
        .plain_out    (plain_out),
        .plain_valid  (plain_valid),
        .RC4_done     (RC4_done),
        .busy         (busy),
        .state_dbg_o  (state_dbg)
    );

    // Clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ct [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] pt [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] exp_pt [9];

    logic [7:0]  exp_q [$];
    int unsigned acc_q [$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard: every plain_valid strobe must match the next expected byte
    // and arrive two edges after that byte was accepted.
    always @(negedge clk) begin
        if (plain_valid) begin
            if (exp_q.size() == 0) begin
                check("pv_spurious", 32'd1, 32'd0);
            end else begin
                check("plain_out", {24'd0, plain_out}, {24'd0, exp_q.pop_front()});
                check("pv_latency", cyc, acc_q.pop_front() + 2);
            end
        end
    end

`ifdef RC4_DROP256_EN
    task automatic build_ref();
        logic [7:0] s [256];
        logic [7:0] kk [3];
        logic [7:0] i, j, t;
        kk = '{8'h4B, 8'h65, 8'h79};
        for (int k = 0; k < 256; k++) s[k] = 8'(k);
        j = 8'd0;
        for (int k = 0; k < 256; k++) begin
            j = j + s[k] + kk[k % 3];
            t = s[k]; s[k] = s[j]; s[j] = t;
        end
        i = 8'd0;
        j = 8'd0;
        for (int k = 0; k < 256; k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        for (int b = 0; b < 9; b++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            exp_pt[b] = ct[b] ^ s[t];
        end
    endtask
`endif

    // Drop RC4_start after done and check the return to IDLE
    task automatic finish_handshake(input string tag);
        repeat (10) @(negedge clk);
        check({tag, "_done_hold"}, {31'd0, RC4_done}, 32'd1);
        check({tag, "_no_restart"}, {31'd0, busy}, 32'd0);
        RC4_start = 1'b0;
        @(negedge clk);
        check({tag, "_done_fall"}, {31'd0, RC4_done}, 32'd0);
        check({tag, "_idle"}, {29'd0, state_dbg}, 32'd0);
    endtask

    // One full job on the known vector; gaps_max > 0 inserts idle cycles
    task automatic run_job(input string tag, input int gaps_max);
        int unsigned c0;
        int unsigned last_acc;
        int n;
        int gap;
        RC4_start = 1'b1;
        num_bytes = 16'd9;
        key       = 24'h79654B;
        c0        = cyc + 1;
        @(negedge clk);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (!cipher_ready && n < 700) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_first"}, cyc - c0, READY_LAT);
        last_acc = 0;
        for (int b = 0; b < 9; b++) begin
            n = 0;
            while (!cipher_ready && n < 8) begin
                @(negedge clk);
                n++;
            end
            check({tag, "_ready_wait"}, {31'd0, cipher_ready}, 32'd1);
            gap = (gaps_max > 0) ? int'($urandom_range(0, gaps_max)) : 0;
            repeat (gap) begin
                @(negedge clk);
                check({tag, "_ready_hold"}, {31'd0, cipher_ready}, 32'd1);
            end
            cipher_valid = 1'b1;
            cipher_in    = ct[b];
            exp_q.push_back(exp_pt[b]);
            acc_q.push_back(cyc + 1);
            last_acc = cyc + 1;
            @(negedge clk);
            cipher_valid = 1'b0;
            cipher_in    = 8'd0;
            check({tag, "_ready_out_low"}, {31'd0, cipher_ready}, 32'd0);
        end
        n = 0;
        while (!RC4_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_edge"}, cyc, last_acc + 1);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
        finish_handshake(tag);
    endtask

    initial begin
        int unsigned c0;
        int n;
        bit seen;

        for (int b = 0; b < 9; b++) exp_pt[b] = pt[b];
`ifdef RC4_DROP256_EN
        build_ref();
`endif

        // Reset with random inputs
        n_rst        = 1'b0;
        RC4_start    = 1'b0;
        key          = 24'h0;
        num_bytes    = 16'd0;
        cipher_in    = 8'd0;
        cipher_valid = 1'b0;
        repeat (2) begin
            RC4_start    = 1'($urandom_range(0, 1));
            cipher_valid = 1'($urandom_range(0, 1));
            cipher_in    = 8'($urandom_range(0, 255));
            num_bytes    = 16'($urandom_range(0, 65535));
            @(negedge clk);
            check("rst_outs", {20'd0, cipher_ready, plain_out, plain_valid, RC4_done, busy}, 32'd0);
        end
        RC4_start    = 1'b0;
        cipher_valid = 1'b0;
        cipher_in    = 8'd0;
        n_rst        = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_outs", {20'd0, cipher_ready, plain_out, plain_valid, RC4_done, busy}, 32'd0);
        end

        // Known vector, back-to-back, then with random gaps
        run_job("known", 0);
        run_job("gaps", 5);

        // Zero-length job
        RC4_start = 1'b1;
        num_bytes = 16'd0;
        c0        = cyc + 1;
        seen      = 1'b0;
        n         = 0;
        @(negedge clk);
        while (!RC4_done && n < 700) begin
            if (cipher_ready) seen = 1'b1;
            @(negedge clk);
            n++;
        end
        check("zero_ready", {31'd0, seen}, 32'd0);
        check("zero_done_lat", cyc - c0, READY_LAT + 1);
        finish_handshake("zero");

        // Reset in the middle of KSA, then a clean restart
        RC4_start = 1'b1;
        num_bytes = 16'd9;
        key       = 24'h79654B;
        repeat (100) @(negedge clk);
        check("mid_busy", {31'd0, busy}, 32'd1);
        n_rst     = 1'b0;
        RC4_start = 1'b0;
        #1;
        check("mid_rst_state", {29'd0, state_dbg}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        run_job("restart", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog against a hung run
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rc4_engine.md
# rc4_engine

RC4 decryption engine answering the MCU's `RC4_start`/`RC4_done` handshake. On start it latches the key and byte count, runs the RC4 key schedule on an internal 256-byte S-box, then XORs the keystream with a ciphertext byte stream. It holds `RC4_done` until the MCU drops `RC4_start`, after which the MCU hands control to edge detection.

## Interface
- KEY_BYTES, 16: key length in bytes (1–256)
- NUM_W, 16: width of the byte count
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- RC4_start  in  1  level request from the MCU; sampled only in IDLE and DONE
- key  in  8*KEY_BYTES  key; byte k is key[8k+7:8k]; latched on start
- num_bytes  in  NUM_W  number of ciphertext bytes to decrypt; latched on start
- cipher_in  in  8  ciphertext byte
- cipher_valid  in  1  cipher_in is valid
- cipher_ready  out  1  engine accepts cipher_in this cycle
- plain_out  out  8  decrypted byte, registered
- plain_valid  out  1  one-cycle strobe marking plain_out
- RC4_done  out  1  level; job complete
- busy  out  1  high in every state except IDLE and DONE

## Operation
- States: IDLE, INIT, KSA, [DROP], STEP, OUT, DONE.
- IDLE: if RC4_start is 1, latch key and num_bytes, then go to INIT.
- INIT (1 cycle): set S[k]=k for all k, i=0, j=0, key index ki=0, then go to KSA.
- KSA (256 cycles, one iteration per cycle):
  - j ← j + S[i] + key byte ki, all mod 256.
  - Swap S[i] and S[j].
  - i ← i + 1; ki wraps at KEY_BYTES−1.
  - After the i=255 iteration, set i=0 and j=0, then go to DROP when configured, otherwise STEP.
- STEP:
  - cipher_ready=1.
  - If num_bytes is 0, go straight to DONE with cipher_ready low.
  - On cipher_valid: latch the byte, i ← i+1, j ← j+S[i_new], swap S[i], S[j], go to OUT.
  - Without cipher_valid: hold state.
- OUT:
  - Register plain_out = byte ^ S[(S[i]+S[j]) mod 256] and pulse plain_valid on the next cycle.
  - Increment the byte count; when count equals num_bytes go to DONE, otherwise STEP.
- DONE: RC4_done=1; return to IDLE on the first edge where RC4_start=0.
- All index arithmetic is 8-bit and wraps mod 256.
- Deasserting RC4_start before DONE is ignored; the job completes.
- plain_out has no backpressure; the consumer must always accept it.

## Timing
- Reset values: cipher_ready=0, plain_out=8'h00, plain_valid=0, RC4_done=0, busy=0; state IDLE; S contents don't-care.
- Reset mid-operation returns to IDLE immediately; the next start re-runs INIT and KSA.
- Edge E0 samples RC4_start=1. INIT follows E0, KSA spans E1–E257, and cipher_ready is first high after E257.
- Byte latency: a byte accepted at edge N gives plain_valid high during the cycle after edge N+2.
- Throughput: at most one byte per 2 cycles; cipher_ready is low in OUT.
- RC4_done rises on the edge that enters DONE and falls on the edge that samples RC4_start=0.
- A start held high through DONE does not retrigger. A new job needs RC4_start low for at least one sampled edge.

## Configuration
- RC4_DROP256_EN defined: adds a DROP state between KSA and STEP.
  - DROP runs 256 PRGA iterations (i/j update and swap), one per cycle, with no output (RC4-drop[256]).
  - cipher_ready first rises after E513.
- RC4_DROP256_EN undefined: DROP is absent and KSA goes directly to STEP (plain RC4).

## Test plan
- Reset: hold n_rst=0 for 2 cycles with random inputs -> all outputs 0 and busy=0; release with RC4_start=0 for 4 cycles -> outputs remain 0.
- Known vector: KEY_BYTES=3, key "Key" (key[7:0]=8'h4B), num_bytes=9, ciphertext BB F3 16 E8 D9 40 AF 0A D3 sent back-to-back -> plain_out "Plaintext" (50 6C 61 69 6E 74 65 78 74), each plain_valid 2 edges after acceptance, then RC4_done=1.
- Stream gaps: same vector with cipher_valid low 0–5 random cycles between bytes -> identical output, and cipher_ready never drops while waiting.
- Zero length: num_bytes=0 -> cipher_ready never asserts and RC4_done rises 258 cycles after E0.
- Done handshake: hold RC4_start high 10 cycles after done -> RC4_done stays 1 with no restart; drop RC4_start -> RC4_done=0 and IDLE the next cycle.
- Mid-run reset: assert n_rst during KSA, then restart with the known vector -> correct plaintext.
- Drop build: compile with RC4_DROP256_EN -> the first cipher_ready moves to E513 and output matches the RC4-drop[256] reference model.
